// File: rtl/mod_n_checker.sv
// Lock detector for a mod-N up counter: hunts for 0, verifies LOCK_LEN in-order
// samples, then flags every sequence violation and every correct wrap while locked.
module mod_n_checker #(
    parameter int N        = 4,
    parameter int SIZE     = 3,
    parameter int LOCK_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] cnt_in,
    output logic            locked,
    output logic            err,
    output logic            wrap,
    output logic [7:0]      err_cnt,
    output logic [SIZE-1:0] expected
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] LAST       = SIZE'(N - 1);
    localparam logic [SIZE:0]   MODULUS    = (SIZE + 1)'(N);
    localparam logic [4:0]      LOCK_LEN_W = 5'(LOCK_LEN);

    function automatic logic [SIZE-1:0] next_val(input logic [SIZE-1:0] v);
        return (v == LAST) ? '0 : v + SIZE'(1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          state_q, state_d;
    logic [SIZE-1:0] expected_q, expected_d;
    logic [3:0]      run_q, run_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic            wrap_q, wrap_d;

    logic            in_range;
    logic            match;
    logic            is_zero;
    logic [4:0]      run_inc;

    assign in_range = ({1'b0, cnt_in} < MODULUS);
    assign match    = in_range && (cnt_in == expected_q);
    assign is_zero  = (cnt_in == '0);
    assign run_inc  = {1'b0, run_q} + 5'd1;

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        err_cnt_d  = err_cnt_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (is_zero) begin
                        state_d    = VERIFY;
                        expected_d = next_val('0);
                        run_d      = 4'd1;
                    end
                end

                VERIFY: begin
                    if (match) begin
                        expected_d = next_val(cnt_in);
                        run_d      = run_inc[3:0];
                        if (run_inc >= LOCK_LEN_W) begin
                            state_d = LOCKED;
                        end
                    end else if (is_zero) begin
                        expected_d = next_val('0);
                        run_d      = 4'd1;
                    end else begin
                        state_d    = HUNT;
                        expected_d = '0;
                        run_d      = 4'd0;
                    end
                end

                LOCKED: begin
                    if (match) begin
                        expected_d = next_val(cnt_in);
                        // Expecting 0 while locked means the last accepted sample was N-1.
                        wrap_d     = is_zero;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                        if (is_zero) begin
                            state_d    = VERIFY;
                            expected_d = next_val('0);
                            run_d      = 4'd1;
                        end else begin
                            state_d    = HUNT;
                            expected_d = '0;
                            run_d      = 4'd0;
                        end
                    end
                end

                default: begin
                    state_d    = HUNT;
                    expected_d = '0;
                    run_d      = 4'd0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= 4'd0;
            err_cnt_q  <= 8'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign wrap     = wrap_q;
    assign err_cnt  = err_cnt_q;
    assign expected = expected_q;

endmodule

// File: tb/tb_mod_n_checker.sv
// Scoreboard bench for mod_n_checker: a behavioural model predicts each sample's
// outputs, which are queued at drive time and compared one cycle later.
module tb_mod_n_checker;

    localparam int N        = 4;
    localparam int SIZE     = 3;
    localparam int LOCK_LEN = 4;

    logic            clk;
    logic            rst;
    logic            en;
    logic [SIZE-1:0] cnt_in;
    logic            locked;
    logic            err;
    logic            wrap;
    logic [7:0]      err_cnt;
    logic [SIZE-1:0] expected;

    mod_n_checker #(.N(N), .SIZE(SIZE), .LOCK_LEN(LOCK_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cnt_in  (cnt_in),
        .locked  (locked),
        .err     (err),
        .wrap    (wrap),
        .err_cnt (err_cnt),
        .expected(expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] err_cnt;
        logic [2:0] expected;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = hunting, 1 = verifying, 2 = locked
    int m_mode;
    int m_exp;
    int m_run;
    int m_cnt;
    int m_prev;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int succ(input int v);
        return (v == N - 1) ? 0 : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_exp  = 0;
        m_run  = 0;
        m_cnt  = 0;
        m_prev = -1;
    endtask

    task automatic model_step(input bit e, input int v);
        exp_t r;
        bit   good;
        r.err  = 1'b0;
        r.wrap = 1'b0;
        if (e) begin
            good = (v < N) && (v == m_exp);
            if (m_mode == 0) begin
                if (v == 0) begin
                    m_mode = 1; m_exp = 1; m_run = 1; m_prev = 0;
                end
            end else if (m_mode == 1) begin
                if (good) begin
                    m_exp = succ(v); m_run = m_run + 1; m_prev = v;
                    if (m_run >= LOCK_LEN) m_mode = 2;
                end else if (v == 0) begin
                    m_exp = 1; m_run = 1; m_prev = 0;
                end else begin
                    m_mode = 0; m_exp = 0; m_run = 0; m_prev = -1;
                end
            end else begin
                if (good) begin
                    if (v == 0 && m_prev == N - 1) r.wrap = 1'b1;
                    m_exp = succ(v); m_prev = v;
                end else begin
                    r.err = 1'b1;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                    if (v == 0) begin
                        m_mode = 1; m_exp = 1; m_run = 1; m_prev = 0;
                    end else begin
                        m_mode = 0; m_exp = 0; m_run = 0; m_prev = -1;
                    end
                end
            end
        end
        r.locked   = (m_mode == 2);
        r.err_cnt  = 8'(m_cnt);
        r.expected = 3'(m_exp);
        sb_q.push_back(r);
    endtask

    task automatic compare_out(input string tag);
        exp_t r;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        r = sb_q.pop_front();
        check_eq({tag, "_locked"},   32'(locked),   32'(r.locked));
        check_eq({tag, "_err"},      32'(err),      32'(r.err));
        check_eq({tag, "_wrap"},     32'(wrap),     32'(r.wrap));
        check_eq({tag, "_err_cnt"},  32'(err_cnt),  32'(r.err_cnt));
        check_eq({tag, "_expected"}, 32'(expected), 32'(r.expected));
        check_eq({tag, "_err_wrap_excl"}, 32'(err & wrap), 32'd0);
    endtask

    task automatic step(input string tag, input bit e, input int v);
        @(negedge clk);
        en     = e;
        cnt_in = 3'(v);
        model_step(e, v);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_locked"},   32'(locked),   32'd0);
        check_eq({tag, "_err"},      32'(err),      32'd0);
        check_eq({tag, "_wrap"},     32'(wrap),     32'd0);
        check_eq({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
        check_eq({tag, "_expected"}, 32'(expected), 32'd0);
    endtask

    task automatic lock_seq(input string tag);
        for (int i = 0; i < 4; i++) step(tag, 1'b1, i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        en     = 1'b0;
        cnt_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic lock and wrap: 0,1,2,3,0,1
        step("seq_0", 1'b1, 0);
        step("seq_1", 1'b1, 1);
        step("seq_2", 1'b1, 2);
        step("seq_3", 1'b1, 3);
        check_eq("lock_rise", 32'(locked), 32'd1);
        step("seq_wrap", 1'b1, 0);
        check_eq("wrap_pulse", 32'(wrap), 32'd1);
        step("seq_1b", 1'b1, 1);
        check_eq("wrap_single", 32'(wrap), 32'd0);

        // Skip-ahead violation while locked, then relock
        step("seq_2b", 1'b1, 2);
        step("seq_3b", 1'b1, 3);
        step("seq_0b", 1'b1, 0);
        step("skip", 1'b1, 2);
        check_eq("skip_err", 32'(err), 32'd1);
        check_eq("skip_cnt", 32'(err_cnt), 32'd1);
        step("after_skip", 1'b1, 1);
        check_eq("err_one_cycle", 32'(err), 32'd0);
        lock_seq("relock");
        check_eq("relocked", 32'(locked), 32'd1);

        // Out-of-range values while locked and while hunting
        step("oor_locked", 1'b1, 5);
        check_eq("oor_err_cnt", 32'(err_cnt), 32'd2);
        step("oor_hunt", 1'b1, 5);
        step("oor_hunt7", 1'b1, 7);

        // Repeated zero restarts verification; mismatch in VERIFY is silent
        step("v_0", 1'b1, 0);
        step("v_0again", 1'b1, 0);
        step("v_1", 1'b1, 1);
        step("v_bad", 1'b1, 3);
        step("v_6", 1'b1, 6);
        lock_seq("lock_en");
        step("lock_en_0", 1'b1, 0);

        // Hold with en low and random inputs, then resume
        for (int i = 0; i < 10; i++) step("en_low", 1'b0, int'($urandom_range(0, 7)));
        check_eq("en_low_locked", 32'(locked), 32'd1);
        check_eq("en_low_expected", 32'(expected), 32'd1);
        for (int i = 1; i < 4; i++) step("resume", 1'b1, i);
        step("resume_wrap", 1'b1, 0);

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            step("sat_viol", 1'b1, 2 + (k % 2));
            lock_seq("sat_relock");
        end
        check_eq("sat_cnt", 32'(err_cnt), 32'd255);
        check_eq("sat_locked", 32'(locked), 32'd1);

        // Asynchronous reset between clock edges while locked
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero_outputs("rst_held");
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        lock_seq("post_rst");
        check_eq("post_rst_locked", 32'(locked), 32'd1);
        check_eq("post_rst_cnt", 32'(err_cnt), 32'd0);
        step("post_rst_wrap", 1'b1, 0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_n_checker.md
MOD_N_CHECKER -- requirements
Module: mod_n_checker

Interface
REQ-001 Parameter N, default 4: counter modulus; legal range 2..2^SIZE.
REQ-002 Parameter SIZE, default 3: width of the observed count bus.
REQ-003 Parameter LOCK_LEN, default 4: consecutive correct samples required to declare lock; legal range 1..15.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 en  input  1  sample qualifier; cnt_in is evaluated only on cycles with en=1.
REQ-007 cnt_in  input  SIZE  count value driven by a mod-N up counter.
REQ-008 locked  output  1  high while the checker is in LOCKED state.
REQ-009 err  output  1  one-cycle pulse on a sequence violation detected while locked.
REQ-010 wrap  output  1  one-cycle pulse on a correct N-1 -> 0 transition observed while locked.
REQ-011 err_cnt  output  8  saturating count of err pulses.
REQ-012 expected  output  SIZE  value the checker requires on the next qualified sample.

Function
REQ-013 All outputs are registered; err, wrap and locked reflect the sample taken on the previous rising edge (1-cycle latency).
REQ-014 next(v) = 0 when v = N-1, else v+1; computed at SIZE bits with no overflow past N-1.
REQ-015 Any cnt_in >= N is a mismatch regardless of state.
REQ-016 States: HUNT, VERIFY, LOCKED; encoding is free.
REQ-017 HUNT: sample == 0 -> VERIFY, expected <= 1, run counter <= 1; any other sample -> stay HUNT, no err.
REQ-018 VERIFY: sample == expected -> expected <= next(sample), run counter++; when the run counter reaches LOCK_LEN -> LOCKED.
REQ-019 VERIFY: mismatch -> if sample == 0, restart VERIFY (expected <= 1, run <= 1), else HUNT; no err pulse, err_cnt unchanged.
REQ-020 LOCKED: sample == expected -> stay LOCKED, expected <= next(sample); wrap pulses when sample == 0 and the previous accepted sample was N-1.
REQ-021 LOCKED: mismatch -> err pulse, err_cnt++ (held at 255 once reached), locked drops on the same edge; next state is VERIFY with expected <= 1 if sample == 0, else HUNT.
REQ-022 en=0: state, expected, run counter and err_cnt hold; err and wrap are 0.
REQ-023 err and wrap never assert together and never assert for more than one cycle per qualified sample.
REQ-024 expected in HUNT is 0.
REQ-025 LOCK_LEN=1: the sample 0 that exits HUNT does not itself lock; the next correct sample locks.

Reset
REQ-026 rst=0 asynchronously forces HUNT, locked=0, err=0, wrap=0, err_cnt=0, expected=0, run counter=0.
REQ-027 Reset asserted mid-sequence, including while locked, discards all history; after deassertion the checker hunts for 0 afresh.
REQ-028 Deassertion is taken synchronously to clk; the first sample is evaluated on the first rising edge with rst=1.

Verification (N=4, SIZE=3, LOCK_LEN=4, en=1 unless stated)
REQ-029 Feed 0,1,2,3,0,1 -> locked rises one cycle after the 4th correct sample (the value 3); wrap pulses once after the 0 that follows 3; err stays 0.
REQ-030 When locked, feed 2 where 1 is expected -> err pulse for one cycle, err_cnt=1, locked=0, state HUNT; then feed 0,1,2,3 -> locked again.
REQ-031 Feed 5 when locked -> err pulse, err_cnt increments; feed 5 in HUNT -> no err, err_cnt unchanged.
REQ-032 Lock, then hold en=0 for 10 cycles with random cnt_in -> locked, expected and err_cnt unchanged, no err/wrap; resume the correct sequence -> no err.
REQ-033 Force 300 locked-state violations (re-locking between them) -> err_cnt saturates at 255 and does not wrap.
REQ-034 Assert rst low between clock edges while locked -> locked, err_cnt and expected go to 0 immediately without waiting for a clk edge; after release the sequence 0,1,2,3 locks again.
